// File: rtl/div_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// Q/R/div_zero are registered and change only on completion or reset.
module div_seq #(
  parameter int unsigned M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  output logic [M-1:0] Q,
  output logic [M-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);

  localparam int unsigned CntW = $clog2(M + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [M-1:0]    dvd_q, dvd_d;
  logic [M-1:0]    dvs_q, dvs_d;
  logic [M-1:0]    rem_q, rem_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [M-1:0]    q_q, q_d;
  logic [M-1:0]    r_q, r_d;
  logic            dz_q, dz_d;

  // Partial remainder with carry bit so divisors above 2^(M-1) cannot overflow.
  logic [M:0]      trial;
  logic            fits;
  logic [M-1:0]    rem_next;
  logic [M-1:0]    dvd_next;

  always_comb begin
    trial    = {rem_q, dvd_q[M-1]};
    fits     = (trial >= {1'b0, dvs_q});
    rem_next = fits ? (trial[M-1:0] - dvs_q) : trial[M-1:0];
    dvd_next = {dvd_q[M-2:0], fits};
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          if (B != '0) begin
            dvd_d   = A;
            dvs_d   = B;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = StRun;
          end else begin
            q_d     = '1;
            r_d     = A;
            dz_d    = 1'b1;
            state_d = StDone;
          end
        end
      end
      StRun: begin
        dvd_d = dvd_next;
        rem_d = rem_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(M - 1)) begin
          q_d     = dvd_next;
          r_d     = rem_next;
          dz_d    = 1'b0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign Q        = q_q;
  assign R        = r_q;
  assign div_zero = dz_q;
  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: M=4 and M=8 instances, results checked on done.
module tb_div_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start4 = 1'b0, start8 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, Q4, R4;
  logic [7:0] a8 = '0, b8 = '0, Q8, R8;
  logic       busy4, done4, dz4, busy8, done8, dz8;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;

  exp_t exp4_q[$];
  exp_t exp8_q[$];
  exp_t e4, e8;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  div_seq #(.M(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
    .Q(Q4), .R(R4), .busy(busy4), .done(done4), .div_zero(dz4)
  );

  div_seq #(.M(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
    .Q(Q8), .R(R8), .busy(busy8), .done(done8), .div_zero(dz8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (rst_n && done4) begin
      if (exp4_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL m4_unexpected_done: got done=1, expected no pending op (t=%0t)", $time);
      end else begin
        e4 = exp4_q.pop_front();
        chk("m4_q", 32'(Q4), 32'(e4.q));
        chk("m4_r", 32'(R4), 32'(e4.r));
        chk("m4_dz", 32'(dz4), 32'(e4.dz));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (exp8_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL m8_unexpected_done: got done=1, expected no pending op (t=%0t)", $time);
      end else begin
        e8 = exp8_q.pop_front();
        chk("m8_q", 32'(Q8), 32'(e8.q));
        chk("m8_r", 32'(R8), 32'(e8.r));
        chk("m8_dz", 32'(dz8), 32'(e8.dz));
      end
    end
  end

  // Issue one M=4 op with hand-computed expectation; checks busy/done timing.
  // poke: drive a different start/A/B during RUN, which must be ignored.
  task automatic op4(input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] q, input logic [3:0] r, input bit poke);
    exp_t e;
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b;
    e.q = {4'b0, q}; e.r = {4'b0, r}; e.dz = (b == 4'd0);
    exp4_q.push_back(e);
    @(posedge clk); #1;
    start4 = 1'b0;
    if (b != 4'd0) begin
      chk("t4_busy_accept", 32'(busy4), 32'd1);
      for (int i = 1; i < 4; i++) begin
        @(posedge clk); #1;
        chk("t4_busy_run", 32'(busy4), 32'd1);
        if (poke && i == 1) begin
          start4 = 1'b1; a4 = ~a; b4 = 4'd1;
        end else begin
          start4 = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    chk("t4_done", 32'(done4), 32'd1);
    chk("t4_busy_done", 32'(busy4), 32'd0);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b;
    if (b == 8'd0) begin
      e.q = 8'hFF; e.r = a; e.dz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    exp8_q.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b0;
    if (b != 8'd0) repeat (8) @(posedge clk);
    #1;
    chk("t8_done", 32'(done8), 32'd1);
  endtask

  initial begin
    #3;
    chk("rst_q", 32'(Q4), 32'd0);
    chk("rst_r", 32'(R4), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_dz", 32'(dz4), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Chained calls start in the DONE cycle: back-to-back with no IDLE gap.
    op4(4'd13, 4'd4,  4'd3,  4'd1, 1'b0);
    op4(4'd15, 4'd1,  4'd15, 4'd0, 1'b0);
    op4(4'd3,  4'd9,  4'd0,  4'd3, 1'b0);
    op4(4'd0,  4'd5,  4'd0,  4'd0, 1'b0);
    op4(4'd15, 4'd15, 4'd1,  4'd0, 1'b0);
    op4(4'd14, 4'd8,  4'd1,  4'd6, 1'b0);
    repeat (3) @(posedge clk);
    op4(4'd7,  4'd0,  4'd15, 4'd7, 1'b0);
    op4(4'd9,  4'd2,  4'd4,  4'd1, 1'b0);
    repeat (4) @(posedge clk); #1;
    chk("hold_q", 32'(Q4), 32'd4);
    chk("hold_r", 32'(R4), 32'd1);
    op4(4'd12, 4'd5,  4'd2,  4'd2, 1'b1);
    repeat (2) @(posedge clk);

    // Reset during the second RUN cycle discards the op.
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd11; b4 = 4'd2;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q", 32'(Q4), 32'd0);
    chk("mid_rst_r", 32'(R4), 32'd0);
    chk("mid_rst_busy", 32'(busy4), 32'd0);
    chk("mid_rst_done", 32'(done4), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("post_rst_q", 32'(Q4), 32'd0);
    chk("post_rst_done", 32'(done4), 32'd0);
    op4(4'd10, 4'd3,  4'd3,  4'd1, 1'b0);

    op8(8'd255, 8'd16);
    for (int i = 0; i < 24; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = (i == 5) ? 8'd0 : 8'($urandom_range(0, 255));
      op8(ra, rb);
    end

    repeat (4) @(posedge clk); #1;
    chk("q4_drained", 32'(exp4_q.size()), 32'd0);
    chk("q8_drained", 32'(exp8_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
